// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns mem-stage load/store requests into bus read / read-modify-write phases.
// Latency: load 3 cycles (IDLE->RD->DONE), store 4 cycles (IDLE->RD->WR->DONE) with a zero-wait bus.
// Backpressure: stall_o freezes the pipeline until DONE; each bus phase aborts after TIMEOUT wait cycles.
module dmem_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  dpram_ce_i,
  input  logic                  dpram_we_i,
  input  logic [ADDR_WIDTH-1:0] dpram_addr_i,
  input  logic [DATA_WIDTH-1:0] dpram_data_i,
  output logic [DATA_WIDTH-1:0] dpram_data_o,
  output logic                  stall_o,
  output logic                  err_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_ready_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Counter must be able to hold TIMEOUT itself (saturation value).
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WAIT_SAT  = CW'(TIMEOUT);

  logic [1:0]            state;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CW-1:0]         wait_cnt;
  logic                  err_q;
  logic                  in_phase;
  logic                  timeout_hit;

  assign in_phase    = (state == RD) || (state == WR);
  // The cycle that would be the TIMEOUT-th unanswered wait cycle ends the phase.
  assign timeout_hit = in_phase && !bus_ready_i && (wait_cnt == WAIT_LAST);

  // Bus outputs decode straight from state so an async reset drops the request at once.
  assign bus_req_o    = in_phase;
  assign bus_we_o     = (state == WR);
  assign bus_addr_o   = addr_q;
  assign bus_wdata_o  = (state == WR) ? dpram_data_i : '0;
  assign dpram_data_o = rdata_q;
  assign err_o        = err_q;
  // Gated by reset so the pipeline is never frozen while the bridge is held in reset.
  assign stall_o      = rst_n_i && dpram_ce_i && (state != DONE);

  // Transaction FSM: latch request, read phase, optional write phase, one release cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      rdata_q  <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dpram_ce_i) begin
            addr_q   <= {dpram_addr_i[ADDR_WIDTH-1:2], 2'b00};
            we_q     <= dpram_we_i;
            wait_cnt <= '0;
            state    <= RD;
          end
        end
        RD: begin
          if (bus_ready_i) begin
            rdata_q  <= bus_rdata_i;
            wait_cnt <= '0;
            state    <= we_q ? WR : DONE;
          end else if (timeout_hit) begin
            rdata_q  <= '0;
            err_q    <= 1'b1;
            wait_cnt <= WAIT_SAT;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WR: begin
          if (bus_ready_i) begin
            state <= DONE;
          end else if (timeout_hit) begin
            rdata_q  <= '0;
            err_q    <= 1'b1;
            wait_cnt <= WAIT_SAT;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed-vector bench for dmem_bridge with a bus-handshake scoreboard.
// A responder process models the bus with per-phase programmable wait states.
// Stimulus pushes expected bus transfers / error pulses; a negedge monitor pops and compares.
module tb_dmem_bridge;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        dpram_ce_i;
  logic        dpram_we_i;
  logic [31:0] dpram_addr_i;
  logic [31:0] dpram_data_i;
  logic [31:0] dpram_data_o;
  logic        stall_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ready_i;
  logic [31:0] bus_rdata_i;

  int total = 0;
  int bad   = 0;

  bus_t exp_q[$];
  int   err_exp = 0;

  int          rd_delay = 0;
  int          wr_delay = 0;
  logic [31:0] rd_data  = '0;

  dmem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .dpram_ce_i   (dpram_ce_i),
    .dpram_we_i   (dpram_we_i),
    .dpram_addr_i (dpram_addr_i),
    .dpram_data_i (dpram_data_i),
    .dpram_data_o (dpram_data_o),
    .stall_o      (stall_o),
    .err_o        (err_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_ready_i  (bus_ready_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus responder: ready after a per-phase number of wait cycles (negative = never).
  initial begin
    int  phase_wait;
    int  dly;
    logic hs;
    phase_wait  = 0;
    bus_ready_i = 1'b0;
    bus_rdata_i = '0;
    forever begin
      @(negedge clk);
      hs = bus_req_o && bus_ready_i;
      @(posedge clk);
      #1;
      if (hs || !bus_req_o) phase_wait = 0;
      if (bus_req_o) begin
        dly         = bus_we_o ? wr_delay : rd_delay;
        bus_rdata_i = bus_we_o ? 32'h0 : rd_data;
        if (dly >= 0 && phase_wait >= dly) begin
          bus_ready_i = 1'b1;
        end else begin
          bus_ready_i = 1'b0;
          phase_wait++;
        end
      end else begin
        bus_ready_i = 1'b0;
      end
    end
  end

  // Monitor: compare every completed bus phase and error pulse against the scoreboard.
  initial begin
    bus_t e;
    logic prev_err;
    logic prev_wait;
    bus_t prev_bus;
    prev_err  = 1'b0;
    prev_wait = 1'b0;
    prev_bus  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n_i) begin
        prev_err  = 1'b0;
        prev_wait = 1'b0;
      end else begin
        if (prev_wait && bus_req_o) begin
          check("stable_we",    {31'd0, bus_we_o}, {31'd0, prev_bus.we});
          check("stable_addr",  bus_addr_o,  prev_bus.addr);
          check("stable_wdata", bus_wdata_o, prev_bus.wdata);
        end
        if (bus_req_o && bus_ready_i) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_bus: we=%0b addr=%h wdata=%h expected none", bus_we_o, bus_addr_o, bus_wdata_o);
          end else begin
            e = exp_q.pop_front();
            check("bus_we",    {31'd0, bus_we_o}, {31'd0, e.we});
            check("bus_addr",  bus_addr_o,  e.addr);
            check("bus_wdata", bus_wdata_o, e.wdata);
          end
        end
        if (err_o) begin
          if (err_exp == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_err: err_o=1 expected 0");
          end else begin
            err_exp--;
            check("err_single_pulse", {31'd0, prev_err}, 32'd0);
          end
        end
        prev_err  = err_o;
        prev_wait = bus_req_o && !bus_ready_i;
        prev_bus  = '{we: bus_we_o, addr: bus_addr_o, wdata: bus_wdata_o};
      end
    end
  end

  // One access: issue in IDLE, count cycles until stall drops (DONE), check latency and read word.
  task automatic do_access(input string nm, input logic we, input logic [31:0] addr,
                           input logic [31:0] exp_addr, input logic [31:0] wdata,
                           input int rdly, input int wdly, input logic [31:0] rdat,
                           input logic [31:0] exp_dout, input int exp_cycles, input logic exp_to);
    int   cycles;
    logic done;
    @(posedge clk);
    #1;
    rd_delay     = rdly;
    wr_delay     = wdly;
    rd_data      = rdat;
    dpram_ce_i   = 1'b1;
    dpram_we_i   = we;
    dpram_addr_i = addr;
    dpram_data_i = wdata;
    if (exp_to) begin
      err_exp++;
    end else begin
      exp_q.push_back('{we: 1'b0, addr: exp_addr, wdata: 32'h0});
      if (we) exp_q.push_back('{we: 1'b1, addr: exp_addr, wdata: wdata});
    end
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (!stall_o) done = 1'b1;
    end
    check({nm, "_latency"}, 32'(cycles), 32'(exp_cycles));
    check({nm, "_dout"}, dpram_data_o, exp_dout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i      = 1'b0;
    dpram_ce_i   = 1'b0;
    dpram_we_i   = 1'b0;
    dpram_addr_i = '0;
    dpram_data_i = '0;
    repeat (2) @(negedge clk);
    dpram_ce_i   = 1'b1;
    dpram_addr_i = 32'h0000_1234;
    #1;
    check("rst_req",   {31'd0, bus_req_o}, 32'd0);
    check("rst_we",    {31'd0, bus_we_o},  32'd0);
    check("rst_addr",  bus_addr_o,   32'h0);
    check("rst_wdata", bus_wdata_o,  32'h0);
    check("rst_dout",  dpram_data_o, 32'h0);
    check("rst_err",   {31'd0, err_o},   32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    dpram_ce_i = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk);

    // Load with one bus wait state.
    do_access("load_100", 1'b0, 32'h100, 32'h100, 32'h0, 1, 0, 32'hDEADBEEF, 32'hDEADBEEF, 4, 1'b0);
    // Unaligned store: read-modify-write against aligned word.
    do_access("store_203", 1'b1, 32'h203, 32'h200, 32'hAA223344, 0, 0, 32'h11223344, 32'h11223344, 4, 1'b0);
    // Read that is never answered: abort after 16 wait cycles.
    do_access("load_to", 1'b0, 32'h40, 32'h40, 32'h0, -1, 0, 32'h99999999, 32'h0, 18, 1'b1);
    // Zero-wait load immediately followed by a zero-wait store.
    do_access("b2b_load", 1'b0, 32'h10, 32'h10, 32'h0, 0, 0, 32'h12345678, 32'h12345678, 3, 1'b0);
    do_access("b2b_store", 1'b1, 32'h16, 32'h14, 32'h0102FFEE, 0, 0, 32'h0102A0B0, 32'h0102A0B0, 4, 1'b0);
    // Store with two write wait states.
    do_access("store_wait", 1'b1, 32'h300, 32'h300, 32'h5A5A5A5A, 0, 2, 32'h0BADF00D, 32'h0BADF00D, 6, 1'b0);

    // Request withdrawn after acceptance: read phase still completes.
    @(posedge clk);
    #1;
    rd_delay     = 2;
    rd_data      = 32'hCAFEF00D;
    dpram_ce_i   = 1'b1;
    dpram_we_i   = 1'b0;
    dpram_addr_i = 32'h501;
    exp_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h0});
    @(posedge clk);
    #1;
    dpram_ce_i = 1'b0;
    repeat (6) @(negedge clk);
    check("ce_drop_dout", dpram_data_o, 32'hCAFEF00D);
    check("ce_drop_idle", {31'd0, bus_req_o}, 32'd0);

    // Reset while a write phase is waiting: request drops at once, no write afterwards.
    @(posedge clk);
    #1;
    rd_delay     = 0;
    wr_delay     = -1;
    rd_data      = 32'h01020304;
    dpram_ce_i   = 1'b1;
    dpram_we_i   = 1'b1;
    dpram_addr_i = 32'h600;
    dpram_data_i = 32'h55667788;
    exp_q.push_back('{we: 1'b0, addr: 32'h600, wdata: 32'h0});
    repeat (4) @(negedge clk);
    check("wr_wait_we",  {31'd0, bus_we_o},  32'd1);
    check("wr_wait_req", {31'd0, bus_req_o}, 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_req",   {31'd0, bus_req_o}, 32'd0);
    check("arst_we",    {31'd0, bus_we_o},  32'd0);
    check("arst_wdata", bus_wdata_o,  32'h0);
    check("arst_addr",  bus_addr_o,   32'h0);
    check("arst_stall", {31'd0, stall_o}, 32'd0);
    check("arst_dout",  dpram_data_o, 32'h0);
    dpram_ce_i = 1'b0;
    wr_delay   = 0;
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_idle", {31'd0, bus_req_o}, 32'd0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("err_all_seen",     32'(err_exp),      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
